// File: rtl/reset_release_sequencer.sv
// rtl/reset_release_sequencer.sv - staged reset release with ready handshake, gap and timeout
// Releases NUM_STAGES reset domains in index order; abort restarts the sequence.
module reset_release_sequencer #(
   parameter int NUM_STAGES  = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 8,
   parameter int TIMEOUT     = 64,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  soft_rst_req,
   input  logic [NUM_STAGES-1:0] stage_ready,
   output logic [NUM_STAGES-1:0] stage_rstn,
   output logic                  seq_done,
   output logic                  seq_error
);

   localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO  = '0;
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

   typedef enum logic [2:0] {
      S_HOLD,
      S_WAIT_RDY,
      S_GAP,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                  state, state_n;
   logic [CNT_W-1:0]        cnt, cnt_n;
   logic [IDX_W-1:0]        idx, idx_n;
   logic [IDX_W-1:0]        idx_inc;
   logic [NUM_STAGES-1:0]   stage_rstn_n;
   logic                    seq_done_n;
   logic                    seq_error_n;

   assign idx_inc = idx + IDX_ONE;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_HOLD;
         cnt        <= CNT_ZERO;
         idx        <= IDX_ZERO;
         stage_rstn <= '0;
         seq_done   <= 1'b0;
         seq_error  <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         stage_rstn <= stage_rstn_n;
         seq_done   <= seq_done_n;
         seq_error  <= seq_error_n;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      idx_n        = idx;
      stage_rstn_n = stage_rstn;
      seq_done_n   = seq_done;
      seq_error_n  = seq_error;

      // Soft request overrides everything, including an in-progress HOLD count.
      if (soft_rst_req) begin
         state_n      = S_HOLD;
         cnt_n        = CNT_ZERO;
         idx_n        = IDX_ZERO;
         stage_rstn_n = '0;
         seq_done_n   = 1'b0;
         seq_error_n  = 1'b0;
      end else begin
         case (state)
            S_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  stage_rstn_n[0] = 1'b1;
                  cnt_n           = CNT_ZERO;
                  state_n         = S_WAIT_RDY;
               end else begin
                  cnt_n = cnt + CNT_ONE;
               end
            end
            S_WAIT_RDY: begin
               // Ready is checked before the timeout so a same-edge ready still passes.
               if (stage_ready[idx]) begin
                  cnt_n = CNT_ZERO;
                  if (idx == IDX_LAST) begin
                     seq_done_n = 1'b1;
                     state_n    = S_DONE;
                  end else begin
                     state_n = S_GAP;
                  end
               end else if (cnt == TO_LAST) begin
                  seq_error_n  = 1'b1;
                  stage_rstn_n = '0;
                  state_n      = S_ERROR;
               end else begin
                  cnt_n = cnt + CNT_ONE;
               end
            end
            S_GAP: begin
               if (cnt == GAP_LAST) begin
                  idx_n                 = idx_inc;
                  stage_rstn_n[idx_inc] = 1'b1;
                  cnt_n                 = CNT_ZERO;
                  state_n               = S_WAIT_RDY;
               end else begin
                  cnt_n = cnt + CNT_ONE;
               end
            end
            S_DONE: begin
            end
            S_ERROR: begin
            end
            default: begin
               state_n      = S_HOLD;
               cnt_n        = CNT_ZERO;
               idx_n        = IDX_ZERO;
               stage_rstn_n = '0;
               seq_done_n   = 1'b0;
               seq_error_n  = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// tb/tb_reset_release_sequencer.sv - directed bench with event-time reference model
// Edge 0 is the clk edge on which the synchronized rstn deasserts.
module tb_reset_release_sequencer;

   localparam int N    = 4;
   localparam int HOLD = 16;
   localparam int GAP  = 8;
   localparam int TO   = 64;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         soft_rst_req = 1'b0;
   logic [N-1:0] stage_ready = '1;
   logic [N-1:0] stage_rstn;
   logic         seq_done;
   logic         seq_error;

   int checks = 0;
   int failures = 0;
   int cur = 0;

   reset_release_sequencer #(
      .NUM_STAGES (N),
      .HOLD_CYCLES(HOLD),
      .STAGE_GAP  (GAP),
      .TIMEOUT    (TO),
      .CNT_W      (8)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .soft_rst_req(soft_rst_req),
      .stage_ready (stage_ready),
      .stage_rstn  (stage_rstn),
      .seq_done    (seq_done),
      .seq_error   (seq_error)
   );

   always #5 clk = ~clk;

   // Reference model in absolute edge times: next release edge, ready deadline.
   int now = 0;
   int m_rel = 0;
   bit m_wait = 0;
   bit m_done = 0;
   bit m_err = 0;
   int t_next = HOLD;
   int t_dead = 0;

   always @(posedge clk) now <= now + 1;

   always @(posedge clk or negedge rstn) begin
      if (!rstn || soft_rst_req) begin
         m_rel  <= 0;
         m_wait <= 0;
         m_done <= 0;
         m_err  <= 0;
         t_next <= now + HOLD;
      end else if (m_done || m_err) begin
      end else if (m_wait) begin
         if (stage_ready[m_rel-1]) begin
            m_wait <= 0;
            if (m_rel == N) m_done <= 1;
            else t_next <= now + GAP;
         end else if (now == t_dead) begin
            m_err  <= 1;
            m_rel  <= 0;
            m_wait <= 0;
         end
      end else if (now == t_next) begin
         m_rel  <= m_rel + 1;
         m_wait <= 1;
         t_dead <= now + TO;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h (edge %0d)", name, act, exp, cur);
      end
   endtask

   task automatic cmp_model();
      logic [N-1:0] exp_rstn;
      exp_rstn = N'((1 << m_rel) - 1);
      chk("model_stage_rstn", 32'(stage_rstn), 32'(exp_rstn));
      chk("model_seq_done", 32'(seq_done), 32'(m_done));
      chk("model_seq_error", 32'(seq_error), 32'(m_err));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cmp_model();
   endtask

   task automatic run_to(input int target);
      while (cur < target) begin
         tick();
         cur++;
      end
   endtask

   task automatic start_seq();
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      cur = 0;
   endtask

   initial begin
      tick();
      chk("reset_stage_rstn", 32'(stage_rstn), 32'h0);
      chk("reset_seq_done", 32'(seq_done), 32'h0);
      chk("reset_seq_error", 32'(seq_error), 32'h0);

      // Normal sequence with all ready high
      stage_ready = 4'b1111;
      start_seq();
      run_to(15); chk("n_e15", 32'(stage_rstn), 32'h0);
      run_to(16); chk("n_e16", 32'(stage_rstn), 32'h1);
      run_to(24); chk("n_e24", 32'(stage_rstn), 32'h1);
      run_to(25); chk("n_e25", 32'(stage_rstn), 32'h3);
      run_to(34); chk("n_e34", 32'(stage_rstn), 32'h7);
      run_to(43); chk("n_e43", 32'(stage_rstn), 32'hf);
      chk("n_done43", 32'(seq_done), 32'h0);
      run_to(44); chk("n_done44", 32'(seq_done), 32'h1);
      chk("n_err44", 32'(seq_error), 32'h0);

      // Timeout on stage 2; stage 3 ready is ignored while waiting on stage 2
      stage_ready = 4'b1011;
      start_seq();
      run_to(34); chk("t_e34", 32'(stage_rstn), 32'h7);
      run_to(97); chk("t_err97", 32'(seq_error), 32'h0);
      chk("t_e97", 32'(stage_rstn), 32'h7);
      run_to(98); chk("t_err98", 32'(seq_error), 32'h1);
      chk("t_rstn98", 32'(stage_rstn), 32'h0);
      chk("t_done98", 32'(seq_done), 32'h0);
      run_to(298); chk("t_err298", 32'(seq_error), 32'h1);
      chk("t_rstn298", 32'(stage_rstn), 32'h0);

      // Held soft request from ERROR, edges 299..303
      soft_rst_req = 1'b1;
      stage_ready  = 4'b1111;
      run_to(299); chk("h_err299", 32'(seq_error), 32'h0);
      chk("h_rstn299", 32'(stage_rstn), 32'h0);
      run_to(303);
      soft_rst_req = 1'b0;
      run_to(318); chk("h_e318", 32'(stage_rstn), 32'h0);
      run_to(319); chk("h_e319", 32'(stage_rstn), 32'h1);
      run_to(346); chk("h_done346", 32'(seq_done), 32'h0);
      run_to(347); chk("h_done347", 32'(seq_done), 32'h1);

      // Single-cycle soft request from DONE at edge 351
      run_to(350);
      soft_rst_req = 1'b1;
      run_to(351);
      soft_rst_req = 1'b0;
      chk("s_rstn351", 32'(stage_rstn), 32'h0);
      chk("s_done351", 32'(seq_done), 32'h0);
      run_to(366); chk("s_e366", 32'(stage_rstn), 32'h0);
      run_to(367); chk("s_e367", 32'(stage_rstn), 32'h1);
      run_to(394); chk("s_done394", 32'(seq_done), 32'h0);
      run_to(395); chk("s_done395", 32'(seq_done), 32'h1);

      // Async reset in the first gap, then full rerun
      start_seq();
      run_to(20); chk("a_e20", 32'(stage_rstn), 32'h1);
      #1 rstn = 1'b0;
      #1;
      chk("a_async_rstn", 32'(stage_rstn), 32'h0);
      chk("a_async_done", 32'(seq_done), 32'h0);
      start_seq();
      run_to(15); chk("a_e15", 32'(stage_rstn), 32'h0);
      run_to(16); chk("a_e16", 32'(stage_rstn), 32'h1);
      run_to(25); chk("a_e25", 32'(stage_rstn), 32'h3);
      run_to(44); chk("a_done44", 32'(seq_done), 32'h1);

      // Stage 1 ready arrives on the last allowed edge (89)
      stage_ready = 4'b1101;
      start_seq();
      run_to(88); chk("b_e88", 32'(stage_rstn), 32'h3);
      stage_ready = 4'b1111;
      run_to(89); chk("b_err89", 32'(seq_error), 32'h0);
      chk("b_e89", 32'(stage_rstn), 32'h3);
      run_to(96); chk("b_e96", 32'(stage_rstn), 32'h3);
      run_to(97); chk("b_e97", 32'(stage_rstn), 32'h7);
      run_to(107); chk("b_done107", 32'(seq_done), 32'h1);
      chk("b_err107", 32'(seq_error), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
